instr_load_buffer: RTL

Synthesizable program buffer at the DUT end of the instruction path: accepts the instruction words the UVM driver writes over a valid/ready load port, stores them in order, then answers the core's fetch requests by byte address with one-cycle latency. It is the receiving/serving counterpart of the testbench instruction writer. It sits between the agent interface and the simprisc core fetch stage.

---
 rtl/instr_load_buffer.sv | 64 ++++++
 1 files changed

// File: rtl/instr_load_buffer.sv
// instr_load_buffer: in-order program store loaded over valid/ready, served to core fetch with 1-cycle latency
module instr_load_buffer #(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          reload,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  output logic          fetch_err,
  output logic [AW:0]   prog_len,
  output logic          running
);
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]  state, state_n;
  logic [AW:0] wptr, wptr_n;
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata;
  logic        err_q, xfer, bad, fire;
  logic [AW-1:0] idx;
  assign xfer = ld_valid && ld_ready && !reload;
  assign fire = fetch_req && !reload;
  assign idx = fetch_addr[AW+1:2];
  assign bad = state != RUN || fetch_addr[1:0] != 2'b00 || |fetch_addr[31:AW+2] || {1'b0, idx} >= wptr;
  always_comb begin
    wptr_n = reload ? '0 : xfer ? wptr + 1'b1 : wptr;
    state_n = reload ? LOAD : (xfer && (ld_last || wptr_n == (AW+1)'(DEPTH))) ? RUN : state;
  end
  // ld_ready is registered from next state so it never depends on ld_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      wptr <= '0;
      ld_ready <= 1'b0;
      fetch_valid <= 1'b0;
      err_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      wptr <= wptr_n;
      ld_ready <= state_n == LOAD;
      fetch_valid <= fire;
      if (fire) begin
        err_q <= bad;
        rdata <= mem[idx];
      end
    end
  end
  always_ff @(posedge clk)
    if (xfer && !rst) mem[wptr[AW-1:0]] <= ld_data;
  assign fetch_instr = err_q ? NOP_WORD : rdata;
  assign fetch_err = err_q;
  assign prog_len = wptr;
  assign running = state == RUN;
endmodule
